// File: rtl/ibus_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : ibus_rom_responder
// Purpose  : Serves naive_mips instruction fetches from a synchronous boot
//            ROM (1-cycle read latency). Each read is stretched by a
//            programmable number of wait cycles through ibus_stall. The block
//            flags premature read withdrawal and writes to ROM, and counts
//            completed fetches.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            ibus_address         - CPU byte address; only [ADDR_WIDTH-1:2] used
//            ibus_byteenable      - unused, full word always returned
//            ibus_read/ibus_write - request strobes, held until completion
//            ibus_wrdata          - unused, ROM is not writable
//            ibus_rddata          - read data, valid in completion cycle, held
//            ibus_stall           - high while a request is pending
//            rom_addr             - combinational word address to the ROM
//            rom_rddata           - registered ROM output
//            err_abort/err_write  - sticky protocol error flags
//            fetch_count          - completed reads, wraps at 2^32
// Revision : 1.0 - initial release
// ============================================================================
module ibus_rom_responder #(
  parameter int ADDR_WIDTH  = 13,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ibus_address,
  input  logic [3:0]            ibus_byteenable,
  input  logic                  ibus_read,
  input  logic                  ibus_write,
  input  logic [31:0]           ibus_wrdata,
  output logic [31:0]           ibus_rddata,
  output logic                  ibus_stall,
  output logic [ADDR_WIDTH-3:0] rom_addr,
  input  logic [31:0]           rom_rddata,
  output logic                  err_abort,
  output logic                  err_write,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Last value of the wait counter before entering DONE; unused when the
  // build has no wait cycles.
  localparam logic [7:0] c_wait_last = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam bit         c_has_wait  = (WAIT_CYCLES > 0);

  state_t                state_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [31:0]           data_q;
  logic [7:0]            cnt_q;
  logic [31:0]           rddata_q;
  logic                  err_abort_q;
  logic                  err_write_q;
  logic [31:0]           count_q;
  logic                  rd_done_q;   // DONE was reached by a read, not a write

  logic [ADDR_WIDTH-3:0] cur_word;

  assign cur_word    = ibus_address[ADDR_WIDTH-1:2];
  assign rom_addr    = cur_word;
  assign ibus_stall  = (ibus_read | ibus_write) & (state_q != ST_DONE);
  assign ibus_rddata = rddata_q;
  assign err_abort   = err_abort_q;
  assign err_write   = err_write_q;
  assign fetch_count = count_q;

  // Address bits outside the decoded window, byte enables and write data
  // carry no meaning for a ROM.
  logic unused_inputs;
  assign unused_inputs = ^{ibus_byteenable, ibus_wrdata,
                           ibus_address[31:ADDR_WIDTH], ibus_address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rddata_q    <= '0;
      err_abort_q <= 1'b0;
      err_write_q <= 1'b0;
      count_q     <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A write wins over a simultaneous read: it is an error either way.
          if (ibus_write) begin
            err_write_q <= 1'b1;
            rd_done_q   <= 1'b0;
            state_q     <= ST_DONE;
          end else if (ibus_read) begin
            addr_q  <= cur_word;
            state_q <= ST_FETCH;
          end
        end

        ST_FETCH, ST_WAIT: begin
          if (ibus_write || !ibus_read) begin
            // Withdrawn read, or a write cutting in: drop the fetch. A write
            // is then served from IDLE on the following cycle.
            err_abort_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (cur_word != addr_q) begin
            // Redirect after a pipeline flush: refetch the new word. The ROM
            // is already registering the new address at this edge.
            addr_q  <= cur_word;
            cnt_q   <= '0;
            state_q <= ST_FETCH;
          end else if (state_q == ST_FETCH) begin
            data_q <= rom_rddata;
            cnt_q  <= '0;
            if (c_has_wait) begin
              state_q <= ST_WAIT;
            end else begin
              // No wait phase: present the ROM word directly in DONE.
              rddata_q  <= rom_rddata;
              rd_done_q <= 1'b1;
              state_q   <= ST_DONE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == c_wait_last) begin
              rddata_q  <= data_q;
              rd_done_q <= 1'b1;
              state_q   <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // The read completes in this cycle only if it is still asserted.
          if (rd_done_q && ibus_read) begin
            count_q <= count_q + 32'd1;
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibus_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibus_rom_responder
// Purpose  : Self-checking bench for ibus_rom_responder. A driver issues
//            directed and random fetches, writes, aborts and redirects and
//            pushes the expected response into a scoreboard queue; a monitor
//            pops and compares on every completion. A second instance with
//            no wait cycles covers the minimum-latency build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibus_rom_responder;

  localparam int AW    = 13;
  localparam int W     = 4;
  localparam int WORDS = 1 << (AW - 2);
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   ibus_address;
  logic [3:0]    ibus_byteenable;
  logic          ibus_read;
  logic          ibus_write;
  logic [31:0]   ibus_wrdata;
  logic [31:0]   ibus_rddata;
  logic          ibus_stall;
  logic [AW-3:0] rom_addr;
  logic [31:0]   rom_rddata;
  logic          err_abort;
  logic          err_write;
  logic [31:0]   fetch_count;

  logic [31:0]   z_address;
  logic          z_read;
  logic          z_write;
  logic [31:0]   z_rddata;
  logic          z_stall;
  logic [AW-3:0] z_rom_addr;
  logic [31:0]   z_rom_rddata;
  logic          z_err_abort;
  logic          z_err_write;
  logic [31:0]   z_fetch_count;

  ibus_rom_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .ibus_address(ibus_address), .ibus_byteenable(ibus_byteenable),
    .ibus_read(ibus_read), .ibus_write(ibus_write), .ibus_wrdata(ibus_wrdata),
    .ibus_rddata(ibus_rddata), .ibus_stall(ibus_stall),
    .rom_addr(rom_addr), .rom_rddata(rom_rddata),
    .err_abort(err_abort), .err_write(err_write), .fetch_count(fetch_count)
  );

  ibus_rom_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .ibus_address(z_address), .ibus_byteenable(4'hF),
    .ibus_read(z_read), .ibus_write(z_write), .ibus_wrdata(32'h0),
    .ibus_rddata(z_rddata), .ibus_stall(z_stall),
    .rom_addr(z_rom_addr), .rom_rddata(z_rom_rddata),
    .err_abort(z_err_abort), .err_write(z_err_write), .fetch_count(z_fetch_count)
  );

  // Boot ROM model: registered output, one cycle after the address.
  logic [31:0] rom [WORDS];
  always @(posedge clk) begin
    rom_rddata   <= rom[rom_addr];
    z_rom_rddata <= rom[z_rom_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_write;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_count;
  logic        exp_err_abort;
  logic        exp_err_write;
  logic [31:0] last_rd;
  bit          rd_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any cycle with a request and no stall is a completion.
  always @(negedge clk) begin
    if (!rst && (ibus_read || ibus_write) && !ibus_stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("completion_kind", {31'b0, ibus_write}, {31'b0, mon_e.is_write});
        if (!mon_e.is_write) chk("rddata", ibus_rddata, mon_e.data);
      end
    end
  end

  // kind: 0 read, 1 read redirected to addr2 at cycle k, 2 read withdrawn at
  // cycle k, 3 write, 4 read replaced by a write at cycle k.
  task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] addr2,
                     input int k, output int done_at);
    int t;
    int exp_lat;
    bit done;
    tick();
    ibus_address    = addr;
    ibus_byteenable = 4'($urandom);
    ibus_wrdata     = $urandom;
    case (kind)
      0: begin ibus_read = 1'b1; exp_lat = 2 + W;     sb.push_back('{1'b0, rom[addr[AW-1:2]]}); end
      1: begin ibus_read = 1'b1; exp_lat = k + 2 + W; sb.push_back('{1'b0, rom[addr2[AW-1:2]]}); end
      2: begin ibus_read = 1'b1; exp_lat = k; end
      3: begin ibus_write = 1'b1; exp_lat = 1;        sb.push_back('{1'b1, 32'h0}); end
      default: begin ibus_read = 1'b1; exp_lat = k + 2; sb.push_back('{1'b1, 32'h0}); end
    endcase
    t = 0;
    done = 0;
    while (!done && t < LIMIT) begin
      @(negedge clk);
      if (!(ibus_read || ibus_write)) done = 1;
      else if (!ibus_stall) done = 1;
      else begin
        tick();
        t++;
        if (t == k) begin
          case (kind)
            1: ibus_address = addr2;
            2: ibus_read = 1'b0;
            4: begin ibus_read = 1'b0; ibus_write = 1'b1; end
            default: ;
          endcase
        end
      end
    end
    if (!done) chk("timeout", 32'd1, 32'd0);
    chk($sformatf("latency_kind%0d", kind), t, exp_lat);
    done_at = cyc;
    case (kind)
      0: begin exp_count = exp_count + 1; last_rd = rom[addr[AW-1:2]];  rd_known = 1; end
      1: begin exp_count = exp_count + 1; last_rd = rom[addr2[AW-1:2]]; rd_known = 1; end
      2: exp_err_abort = 1'b1;
      3: begin exp_err_write = 1'b1; rd_known = 0; end
      default: begin exp_err_abort = 1'b1; exp_err_write = 1'b1; rd_known = 0; end
    endcase
    tick();
    ibus_read  = 1'b0;
    ibus_write = 1'b0;
    @(negedge clk);
    chk("fetch_count", fetch_count, exp_count);
    chk("err_abort", {31'b0, err_abort}, {31'b0, exp_err_abort});
    chk("err_write", {31'b0, err_write}, {31'b0, exp_err_write});
    chk("stall_idle", {31'b0, ibus_stall}, 32'd0);
    if (rd_known) chk("rddata_hold", ibus_rddata, last_rd);
  endtask

  task automatic z_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] exp_cnt);
    int t;
    tick();
    z_address = addr;
    if (is_wr) z_write = 1'b1; else z_read = 1'b1;
    t = 0;
    while (t < LIMIT) begin
      @(negedge clk);
      if (!z_stall) break;
      tick();
      t++;
    end
    chk(is_wr ? "z_write_latency" : "z_read_latency", t, is_wr ? 32'd1 : 32'd2);
    if (!is_wr) chk("z_rddata", z_rddata, rom[addr[AW-1:2]]);
    tick();
    z_read  = 1'b0;
    z_write = 1'b0;
    @(negedge clk);
    chk("z_fetch_count", z_fetch_count, exp_cnt);
    chk("z_err_write", {31'b0, z_err_write}, {31'b0, is_wr});
    chk("z_err_abort", {31'b0, z_err_abort}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, d;
    int kind, sel, k;
    logic [31:0] a, a2, delta;

    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
    rst = 1'b1;
    ibus_address = '0; ibus_byteenable = '0; ibus_read = 1'b0;
    ibus_write = 1'b0; ibus_wrdata = '0;
    z_address = '0; z_read = 1'b0; z_write = 1'b0;
    exp_count = '0; exp_err_abort = 1'b0; exp_err_write = 1'b0;
    last_rd = '0; rd_known = 1;

    repeat (3) tick();
    @(negedge clk);
    chk("reset_rddata", ibus_rddata, 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    chk("reset_errs", {30'b0, err_abort, err_write}, 32'h0);
    chk("reset_stall", {31'b0, ibus_stall}, 32'h0);
    chk("z_reset_count", z_fetch_count, 32'h0);
    tick();
    rst = 1'b0;

    // Single fetch with the boot vector.
    rom[0] = 32'h3C088000;
    txn(0, 32'h80000000, 32'h0, 0, d);

    // Two consecutive fetches, one idle cycle between them from the driver.
    rom[0] = 32'h11111111;
    rom[1] = 32'h22222222;
    txn(0, 32'h80000000, 32'h0, 0, d1);
    txn(0, 32'h80000004, 32'h0, 0, d2);
    chk("b2b_gap", d2 - d1, 32'd8);

    // Redirect mid-WAIT to word 4, then withdraw a read after two WAIT cycles.
    txn(1, 32'h80000000, 32'h80000010, 3, d);
    txn(2, 32'h80000008, 32'h0, 4, d);

    // Write to ROM.
    txn(3, 32'h80000000, 32'h0, 0, d);

    // Reset while in FETCH with the read still held.
    tick();
    ibus_address = 32'h80000020;
    ibus_read = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_rddata", ibus_rddata, 32'h0);
    chk("rst_mid_count", fetch_count, 32'h0);
    chk("rst_mid_errs", {30'b0, err_abort, err_write}, 32'h0);
    chk("rst_mid_stall", {31'b0, ibus_stall}, 32'd1);
    tick();
    rst = 1'b0;
    ibus_read = 1'b0;
    exp_count = '0; exp_err_abort = 1'b0; exp_err_write = 1'b0;
    last_rd = '0; rd_known = 1;
    txn(0, 32'h80000020, 32'h0, 0, d);

    // Zero-wait build.
    z_txn(1'b0, 32'h8000000C, 32'd1);
    z_txn(1'b1, 32'h80000000, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      kind = (sel < 5) ? 0 : (sel < 7) ? 1 : (sel == 7) ? 2 : (sel == 8) ? 3 : 4;
      a = $urandom;
      delta = 32'($urandom_range(1, WORDS - 1)) << 2;
      a2 = a ^ delta;
      k = $urandom_range(1, 1 + W);
      repeat ($urandom_range(0, 2)) tick();
      txn(kind, a, a2, k, d);
    end

    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibus_rom_responder.md
# ibus_rom_responder

Synthesizable instruction-bus responder that serves `naive_mips` fetches from a synchronous on-chip boot ROM. It sits on the CPU's `ibus_*` port and converts each request into a ROM access plus a programmable number of wait cycles, signalled through `ibus_stall`. It also flags protocol violations (premature abort, writes to ROM) and counts completed fetches, so the same block serves FPGA boot and stall-path verification.

## Interface
Parameters:
- ADDR_WIDTH, 13, byte-address bits decoded; ROM depth is 2^(ADDR_WIDTH-2) words
- WAIT_CYCLES, 4, extra stall cycles inserted after ROM data returns (0..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- ibus_address  in  32  byte address from CPU; bits [1:0] ignored, bits above ADDR_WIDTH-1 ignored
- ibus_byteenable  in  4  ignored; full word always returned
- ibus_read  in  1  read request, held by CPU until completion
- ibus_write  in  1  write request (illegal target)
- ibus_wrdata  in  32  ignored
- ibus_rddata  out  32  read data, valid in the completion cycle, held afterwards
- ibus_stall  out  1  high while a request is pending and not complete
- rom_addr  out  ADDR_WIDTH-2  word address to ROM, combinational = ibus_address[ADDR_WIDTH-1:2]
- rom_rddata  in  32  ROM output, registered inside ROM (1-cycle latency)
- err_abort  out  1  sticky: a read was withdrawn before completion
- err_write  out  1  sticky: a write was presented
- fetch_count  out  32  completed reads, wraps at 2^32

## Operation
- States: IDLE, FETCH, WAIT, DONE.
- ibus_stall = (ibus_read | ibus_write) & (state != DONE); combinational.
- A transaction completes in the cycle where request is high and ibus_stall is low; only DONE produces that.
- IDLE: ibus_write -> DONE, set err_write (write takes priority if read also high). ibus_read -> capture addr_q = ibus_address[ADDR_WIDTH-1:2], go FETCH. Otherwise stay.
- FETCH: rom_rddata corresponds to addr_q; latch into data_q, cnt <= 0; go WAIT if WAIT_CYCLES>0 else DONE.
- WAIT: cnt increments; on cnt == WAIT_CYCLES-1 go DONE.
- DONE: ibus_rddata <= data_q (registered at entry to DONE, so valid throughout DONE); if read, fetch_count++ at this edge; go IDLE.
- Abort: in FETCH/WAIT, if ibus_read and ibus_write are both low -> set err_abort, go IDLE, no count, ibus_rddata unchanged.
- Restart: in FETCH/WAIT, if ibus_read high and ibus_address[ADDR_WIDTH-1:2] != addr_q -> addr_q <= new word, go FETCH, cnt cleared, no error (pipeline flush redirect).
- Write arriving while in FETCH/WAIT: treated as abort of the read (err_abort) and then handled from IDLE next cycle.
- err_* cleared only by rst.

## Timing
- Reset: state IDLE, ibus_rddata 0, err_abort 0, err_write 0, fetch_count 0, cnt 0, addr_q 0. ibus_stall remains combinational (high if a request is present during rst).
- Read latency: request seen in cycle T0; stall high T0..T(1+WAIT_CYCLES); completion in T(2+WAIT_CYCLES). WAIT_CYCLES=4 -> complete at T6.
- Back-to-back reads: DONE -> IDLE costs one cycle; next request starts in T(3+WAIT_CYCLES), sustained throughput 1 word per 3+WAIT_CYCLES cycles.
- Write: stall high in T0, complete in T1.
- rst asserted mid-transaction: next cycle state IDLE, no completion, counters cleared.
- fetch_count at 0xFFFFFFFF wraps to 0 on next completion.

## Test plan
- WAIT_CYCLES=4, ROM[0x000]=0x3C088000, hold read at 0x80000000 -> stall high 6 cycles, low in 7th with ibus_rddata=0x3C088000, fetch_count=1.
- Two consecutive reads 0x80000000, 0x80000004 (ROM 0x11111111, 0x22222222) -> both returned in order, completions 8 cycles apart, fetch_count=2.
- Drop ibus_read in WAIT after 2 cycles -> err_abort=1, state IDLE, ibus_rddata unchanged, fetch_count unchanged.
- Change address 0x80000000->0x80000010 mid-WAIT while read held -> data of word 4 returned, completion 6 cycles after change, err_abort=0.
- ibus_write to 0x80000000 -> stall high 1 cycle, completes next, err_write=1, ROM untouched; WAIT_CYCLES=0 build: read completes in T2.
- Assert rst during FETCH -> all outputs at reset values next cycle, subsequent read completes normally.
